decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/immediate/PC width; legal values 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-decode counter.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  discard held and incoming instruction.
REQ-006 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept.
REQ-008 SHALL have port in_instr  input  32  raw instruction.
REQ-009 SHALL have port in_pc  input  XLEN  instruction address.
REQ-010 SHALL have port out_valid  output  1  decoded bundle valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have ports out_pc (XLEN), out_imm (XLEN), out_rd/out_rs1/out_rs2 (5), out_funct3 (3), out_funct7b5 (1), out_fmt (3), out_reg_write (1), out_illegal (1), all outputs, registered.
REQ-013 SHALL have port decode_count  output  CNT_W  count of bundles handed downstream.

Function
REQ-014 SHALL hold one entry; state EMPTY/FULL, out_valid = FULL.
REQ-015 SHALL drive in_ready = !FULL || out_ready, combinationally; accept = in_valid && in_ready.
REQ-016 Transitions: EMPTY+accept -> FULL; FULL+out_ready+!accept -> EMPTY; FULL+out_ready+accept -> FULL with new bundle (back-to-back, no bubble); FULL+!out_ready -> hold all outputs stable.
REQ-017 Latency SHALL be exactly 1 cycle from accept to out_valid.
REQ-018 flush SHALL have priority: next state EMPTY, same-cycle accept discarded, counter not incremented that cycle.
REQ-019 out_fmt encoding: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
REQ-020 Opcode map: 0110011 R; 0010011, 0000011, 1100111 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J; any other -> ILL with out_illegal=1.
REQ-021 Register fields: R,S,B use rs2=instr[24:20]; R,I,S,B use rs1=instr[19:15]; R,I,U,J use rd=instr[11:7]; unused fields SHALL be 0; ILL SHALL zero rd/rs1/rs2.
REQ-022 funct3 = instr[14:12] for R,I,S,B, else 0; funct7b5 = instr[30] for R and for I with opcode 0010011 and funct3=101, else 0.
REQ-023 Immediates, sign-extended from instr[31] to XLEN: I {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0}; J {instr[31],instr[19:12],instr[20],instr[30:21],0}; U {instr[31:12],12'b0}; R and ILL -> 0.
REQ-024 out_reg_write = 1 for R,I,U,J when rd != 0, else 0 (x0 writes suppressed).
REQ-025 decode_count SHALL increment by 1 on out_valid && out_ready && !flush, saturating at 2^CNT_W-1.
REQ-026 Decode logic SHALL be free of latches; every output fully assigned for every opcode.

Reset
REQ-027 On reset low, asynchronously: state EMPTY, out_valid=0, all bundle outputs 0, decode_count=0.
REQ-028 in_ready SHALL be 1 while reset is low and on the first cycle after release.
REQ-029 Reset mid-transfer SHALL drop the held bundle with no downstream handshake.

Verification
REQ-030 addi x5,x1,-1 (0xFFF08293), pc=0x100, out_ready=1 -> next cycle out_valid=1, fmt=1, rd=5, rs1=1, rs2=0, imm=0xFFFFFFFF, reg_write=1, count=1.
REQ-031 beq x1,x2,-4 (0xFE208EE3) with XLEN=64 -> fmt=3, rd=0, imm=0xFFFFFFFFFFFFFFFC, reg_write=0.
REQ-032 Stream 4 instructions with out_ready low cycles 2-3 -> outputs held stable while stalled, in_ready=0 while FULL, all 4 delivered in order, count=4.
REQ-033 flush while FULL and in_valid=1 -> next cycle out_valid=0, count unchanged, no bundle emitted.
REQ-034 Opcode 0x7F, then lui x0,0x12345 -> first fmt=7, illegal=1, rd=rs1=rs2=0; second fmt=4, imm=0x12345000, reg_write=0.
REQ-035 Counter with CNT_W=2, 5 deliveries -> decode_count stays 3; reset low mid-stall -> out_valid=0 and count=0 immediately.

Source files
------------

// File: rtl/decode_stage.sv
// RV32/RV64 base-ISA decode stage: one-entry skid register with valid/ready
// handshake, flush, and a saturating count of bundles handed downstream.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic             out_funct7b5,
  output logic [2:0]       out_fmt,
  output logic             out_reg_write,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decode_count
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef enum logic {EMPTY, FULL} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [2:0]      fmt;
    logic            reg_write;
    logic            illegal;
  } bundle_t;

  state_e     state_q, state_d;
  bundle_t    bundle_q, bundle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [6:0]  op;
  logic [31:0] imm32;
  logic        is_r, is_i, is_s, is_b, is_u, is_j;
  logic        accept, load;

  assign op   = in_instr[6:0];
  assign is_r = (op == 7'b0110011);
  assign is_i = (op == 7'b0010011) || (op == 7'b0000011) ||
                (op == 7'b1100111);
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_u = (op == 7'b0110111) || (op == 7'b0010111);
  assign is_j = (op == 7'b1101111);

  // Immediates are built as 32-bit signed values, then widened to XLEN.
  always_comb begin
    bundle_d = '0;
    imm32    = '0;
    bundle_d.pc = in_pc;
    unique case (1'b1)
      is_r: begin
        bundle_d.fmt       = FMT_R;
        bundle_d.rd        = in_instr[11:7];
        bundle_d.rs1       = in_instr[19:15];
        bundle_d.rs2       = in_instr[24:20];
        bundle_d.funct3    = in_instr[14:12];
        bundle_d.funct7b5  = in_instr[30];
        bundle_d.reg_write = (in_instr[11:7] != 5'd0);
      end
      is_i: begin
        bundle_d.fmt       = FMT_I;
        bundle_d.rd        = in_instr[11:7];
        bundle_d.rs1       = in_instr[19:15];
        bundle_d.funct3    = in_instr[14:12];
        bundle_d.funct7b5  = (op == 7'b0010011) &&
                             (in_instr[14:12] == 3'b101) &&
                             in_instr[30];
        bundle_d.reg_write = (in_instr[11:7] != 5'd0);
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      is_s: begin
        bundle_d.fmt    = FMT_S;
        bundle_d.rs1    = in_instr[19:15];
        bundle_d.rs2    = in_instr[24:20];
        bundle_d.funct3 = in_instr[14:12];
        imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                 in_instr[11:7]};
      end
      is_b: begin
        bundle_d.fmt    = FMT_B;
        bundle_d.rs1    = in_instr[19:15];
        bundle_d.rs2    = in_instr[24:20];
        bundle_d.funct3 = in_instr[14:12];
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                 in_instr[30:25], in_instr[11:8], 1'b0};
      end
      is_u: begin
        bundle_d.fmt       = FMT_U;
        bundle_d.rd        = in_instr[11:7];
        bundle_d.reg_write = (in_instr[11:7] != 5'd0);
        imm32 = {in_instr[31:12], 12'b0};
      end
      is_j: begin
        bundle_d.fmt       = FMT_J;
        bundle_d.rd        = in_instr[11:7];
        bundle_d.reg_write = (in_instr[11:7] != 5'd0);
        imm32 = {{11{in_instr[31]}}, in_instr[31],
                 in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      default: begin
        bundle_d.fmt     = FMT_ILL;
        bundle_d.illegal = 1'b1;
      end
    endcase
    bundle_d.imm = XLEN'($signed(imm32));
  end

  always_comb begin
    in_ready = (state_q == EMPTY) || out_ready;
    accept   = in_valid && in_ready;
    load     = accept && !flush;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
    end else if (out_ready) begin
      state_d = EMPTY;
    end
    if ((state_q == FULL) && out_ready && !flush &&
        (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      bundle_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        bundle_q <= bundle_d;
      end
    end
  end

  assign out_valid     = (state_q == FULL);
  assign out_pc        = bundle_q.pc;
  assign out_imm       = bundle_q.imm;
  assign out_rd        = bundle_q.rd;
  assign out_rs1       = bundle_q.rs1;
  assign out_rs2       = bundle_q.rs2;
  assign out_funct3    = bundle_q.funct3;
  assign out_funct7b5  = bundle_q.funct7b5;
  assign out_fmt       = bundle_q.fmt;
  assign out_reg_write = bundle_q.reg_write;
  assign out_illegal   = bundle_q.illegal;
  assign decode_count  = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a 32-bit/16-bit-counter instance and a
// 64-bit/2-bit-counter instance driven by the same stimulus.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] pc64;

  logic        in_ready, o_valid;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [2:0]  o_f3, o_fmt;
  logic        o_f7, o_rw, o_ill;
  logic [15:0] o_cnt;

  logic        w_ready, w_valid;
  logic [63:0] w_pc, w_imm;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3, w_fmt;
  logic        w_f7, w_rw, w_ill;
  logic [1:0]  w_cnt;

  decode_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(pc64[31:0]),
    .out_valid(o_valid), .out_ready(out_ready),
    .out_pc(o_pc), .out_imm(o_imm),
    .out_rd(o_rd), .out_rs1(o_rs1), .out_rs2(o_rs2),
    .out_funct3(o_f3), .out_funct7b5(o_f7),
    .out_fmt(o_fmt), .out_reg_write(o_rw),
    .out_illegal(o_ill), .decode_count(o_cnt)
  );

  decode_stage #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(w_ready),
    .in_instr(in_instr), .in_pc(pc64),
    .out_valid(w_valid), .out_ready(out_ready),
    .out_pc(w_pc), .out_imm(w_imm),
    .out_rd(w_rd), .out_rs1(w_rs1), .out_rs2(w_rs2),
    .out_funct3(w_f3), .out_funct7b5(w_f7),
    .out_fmt(w_fmt), .out_reg_write(w_rw),
    .out_illegal(w_ill), .decode_count(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic        rw;
    logic        ill;
    logic [63:0] imm;
  } vec_t;

  vec_t vt [11];
  int   n_chk;
  int   n_fail;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int          k, got;
    logic        prev_stall, acc;
    logic [4:0]  snap_rd;
    logic [31:0] snap_imm;
    logic [63:0] e_imm;
    logic [63:0] e_pc;

    vt[0]  = '{32'hFFF08293, 3'd1, 5'd5,  5'd1, 5'd0, 3'd0, 1'b0,
               1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vt[1]  = '{32'hFE208EE3, 3'd3, 5'd0,  5'd1, 5'd2, 3'd0, 1'b0,
               1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
    vt[2]  = '{32'h0000007F, 3'd7, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0,
               1'b0, 1'b1, 64'h0};
    vt[3]  = '{32'h12345037, 3'd4, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0,
               1'b0, 1'b0, 64'h0000_0000_1234_5000};
    vt[4]  = '{32'h405201B3, 3'd0, 5'd3,  5'd4, 5'd5, 3'd0, 1'b1,
               1'b1, 1'b0, 64'h0};
    vt[5]  = '{32'h40345393, 3'd1, 5'd7,  5'd8, 5'd0, 3'd5, 1'b1,
               1'b1, 1'b0, 64'h403};
    vt[6]  = '{32'hFE612C23, 3'd2, 5'd0,  5'd2, 5'd6, 3'd2, 1'b0,
               1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8};
    vt[7]  = '{32'h001000EF, 3'd5, 5'd1,  5'd0, 5'd0, 3'd0, 1'b0,
               1'b1, 1'b0, 64'h800};
    vt[8]  = '{32'h80000517, 3'd4, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0,
               1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000};
    vt[9]  = '{32'h0044A003, 3'd1, 5'd0,  5'd9, 5'd0, 3'd2, 1'b0,
               1'b0, 1'b0, 64'h4};
    vt[10] = '{32'h00008067, 3'd1, 5'd0,  5'd1, 5'd0, 3'd0, 1'b0,
               1'b0, 1'b0, 64'h0};

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_instr = 32'h0;
    pc64 = 64'h0;

    #3;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(o_cnt), 64'd0);
    chk("rst_bundle", {o_imm, o_pc}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_ready", 64'(in_ready), 64'd1);

    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_instr = vt[i].instr;
      e_pc = 64'hA000_0000_0000_0100 + 64'(4 * i);
      pc64 = e_pc;
      @(posedge clk); #1;
      e_imm = vt[i].imm;
      chk($sformatf("v%0d_valid", i), 64'(o_valid), 64'd1);
      chk($sformatf("v%0d_fields", i),
          64'({o_fmt, o_rd, o_rs1, o_rs2, o_f3, o_f7, o_rw, o_ill}),
          64'({vt[i].fmt, vt[i].rd, vt[i].rs1, vt[i].rs2,
               vt[i].f3, vt[i].f7, vt[i].rw, vt[i].ill}));
      chk($sformatf("v%0d_imm32", i), 64'(o_imm), 64'(e_imm[31:0]));
      chk($sformatf("v%0d_imm64", i), w_imm, e_imm);
      chk($sformatf("v%0d_pc32", i), 64'(o_pc), 64'(e_pc[31:0]));
      chk($sformatf("v%0d_pc64", i), w_pc, e_pc);
      chk($sformatf("v%0d_fmt64", i), 64'(w_fmt), 64'(vt[i].fmt));
      chk($sformatf("v%0d_count", i), 64'(o_cnt), 64'(i));
      chk($sformatf("v%0d_count2", i), 64'(w_cnt),
          64'((i > 3) ? 3 : i));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", 64'(o_valid), 64'd0);
    chk("drain_count", 64'(o_cnt), 64'd11);
    chk("sat_count2", 64'(w_cnt), 64'd3);

    // flush while FULL with a new instruction offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00A00113;
    @(posedge clk); #1;
    chk("fl_full", 64'(o_valid), 64'd1);
    chk("fl_rd", 64'(o_rd), 64'd2);
    flush = 1'b1;
    out_ready = 1'b1;
    in_instr = 32'h00B00193;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(o_valid), 64'd0);
    chk("fl_count", 64'(o_cnt), 64'd11);
    @(posedge clk); #1;
    chk("fl_after_valid", 64'(o_valid), 64'd0);
    chk("fl_after_count", 64'(o_cnt), 64'd11);

    rst_n = 1'b0;
    #2;
    chk("rst2_count", 64'(o_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // four-instruction stream, downstream stalled on cycles 2 and 3
    k = 0;
    got = 0;
    prev_stall = 1'b0;
    snap_rd = '0;
    snap_imm = '0;
    for (int c = 0; c < 24 && got < 4; c++) begin
      out_ready = !(c == 2 || c == 3);
      in_valid = (k < 4);
      in_instr = 32'((k + 1) << 20) | 32'((k + 1) << 7) | 32'h13;
      pc64 = 64'h200 + 64'(4 * k);
      @(negedge clk);
      if (prev_stall) begin
        chk($sformatf("hold_rd_c%0d", c), 64'(o_rd), 64'(snap_rd));
        chk($sformatf("hold_imm_c%0d", c), 64'(o_imm),
            64'(snap_imm));
      end
      if (o_valid && !out_ready)
        chk($sformatf("stall_ready_c%0d", c), 64'(in_ready), 64'd0);
      if (o_valid && out_ready) begin
        chk($sformatf("ord_rd_%0d", got), 64'(o_rd), 64'(got + 1));
        chk($sformatf("ord_imm_%0d", got), 64'(o_imm), 64'(got + 1));
        got++;
      end
      prev_stall = o_valid && !out_ready;
      snap_rd = o_rd;
      snap_imm = o_imm;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("stream_delivered", 64'(got), 64'd4);
    chk("stream_count", 64'(o_cnt), 64'd4);
    chk("stream_count2", 64'(w_cnt), 64'd3);

    // reset asserted while a bundle is held under stall
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hFFF08293;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_full", 64'(o_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_count", 64'(o_cnt), 64'd0);
    chk("mid_rst_count2", 64'(w_cnt), 64'd0);
    chk("mid_rst_bundle", {27'd0, o_rd, o_imm}, 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rel_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_valid", 64'(o_valid), 64'd0);
    chk("mid_rel_count", 64'(o_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
